xbar_tx_serializer: RTL
=======================

XBAR_TX_SERIALIZER -- requirements
Module: xbar_tx_serializer

Interface
REQ-001 SHALL have parameter: DATA_W, default 8, payload bits per frame (ports' decoded_out byte width).
REQ-002 SHALL have parameter: FIFO_DEPTH, default 4, power of two, words buffered ahead of the shifter.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: bit_en  input  1  bit-period strobe (one-cycle pulse per serial bit, e.g. from clk10 divider).
REQ-006 SHALL have port: in_valid  input  1  parallel word offered.
REQ-007 SHALL have port: in_data  input  DATA_W  parallel word from switch output side.
REQ-008 SHALL have port: in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have port: serial_out  output  1  registered serial line to the port's serial_in.
REQ-010 SHALL have port: busy  output  1  a frame is in progress (state != IDLE).
REQ-011 SHALL have port: fifo_count  output  $clog2(FIFO_DEPTH)+1  words held in FIFO.

Function
REQ-012 SHALL accept a word when in_valid && in_ready on a rising edge; in_data is not sampled otherwise.
REQ-013 SHALL drive in_ready = (fifo_count != FIFO_DEPTH), combinationally from registered count; when full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-014 SHALL update fifo_count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; read/write pointers wrap modulo FIFO_DEPTH.
REQ-015 SHALL emit frame: start bit 0, DATA_W data bits MSB first, even-parity bit (XOR of data bits), stop bit 1 -- DATA_W+3 bit periods.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; state, serial_out and bit counter change only on cycles with bit_en=1.
REQ-017 IDLE: serial_out=1; on bit_en with fifo_count>0, pop head into shift register, serial_out<=0, go START; with fifo empty stay IDLE.
REQ-018 START on bit_en: serial_out<=data[DATA_W-1], bit counter<=0, go DATA.
REQ-019 DATA on bit_en: if counter<DATA_W-1, output next lower data bit, counter+1; else serial_out<=parity, go PARITY.
REQ-020 PARITY on bit_en: serial_out<=1, go STOP.
REQ-021 STOP on bit_en: if fifo_count>0, pop, serial_out<=0, go START (no idle gap); else go IDLE, serial_out stays 1.
REQ-022 Pop SHALL occur in the same cycle as the REQ-017/REQ-021 transition; a word pushed into an empty FIFO SHALL be poppable on the next bit_en at the earliest (no FIFO bypass).
REQ-023 bit_en=0 SHALL freeze state, counter, shift register and serial_out; FIFO push still operates.
REQ-024 busy SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE.

Reset
REQ-025 On rst=1 at a rising edge: state<=IDLE, serial_out<=1, busy=0, fifo_count<=0, pointers<=0, counter<=0, in_ready=1 next cycle.
REQ-026 rst SHALL override bit_en and in_valid in the same cycle; a frame in progress is aborted, line returns to 1, buffered words discarded.

Verification
REQ-027 Push 0xA5 into empty FIFO, bit_en every cycle -> serial_out over 11 bit_en periods: 0,1,0,1,0,0,1,0,1,0,1 then idle 1; busy high exactly 11 periods.
REQ-028 Push 0x01 then 0x80 back-to-back -> second start bit immediately follows first stop bit; parity bits 1 and 1; no idle period between frames.
REQ-029 bit_en=0, push 5 words 0x10..0x14 -> in_ready drops after 4th accept, fifo_count=4, 0x14 not accepted; enable bit_en -> frames 0x10..0x13 in order.
REQ-030 Full FIFO, in_valid=1 on the cycle a pop occurs -> push refused that cycle, fifo_count 4->3, accepted next cycle (count back to 4).
REQ-031 Assert rst during DATA bit 3 of 0x3C with 2 words queued -> next cycle serial_out=1, busy=0, fifo_count=0, in_ready=1; no further frames.
REQ-032 bit_en pulsed every 4th cycle -> each serial bit held exactly 4 cycles; bit_en held low mid-frame -> serial_out and busy frozen.

Source files
------------

// File: rtl/xbar_tx_serializer.sv
// Crossbar egress serializer: buffers parallel words in a small FIFO and shifts
// each one out as a start / MSB-first data / even-parity / stop frame, paced by bit_en.
module xbar_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_en,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    // state  | meaning
    // IDLE   | line at 1, waiting for a buffered word
    // START  | start bit (0) on the line
    // DATA   | data bits on the line, MSB first
    // PARITY | even-parity bit on the line
    // STOP   | stop bit (1) on the line; may chain straight into the next START

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              par;
    logic              par_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              sout_nxt;

    // Full blocks the push even when a pop frees a slot in the same cycle.
    assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            shreg      <= '0;
            par        <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            serial_out <= sout_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // Pop decisions use the registered count, so a word pushed this cycle waits for the next bit_en.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        par_nxt   = par;
        cnt_nxt   = cnt;
        sout_nxt  = serial_out;
        pop       = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE, STOP: begin
                    if (fifo_count != '0) begin
                        pop       = 1'b1;
                        shreg_nxt = mem[rd_ptr];
                        par_nxt   = ^mem[rd_ptr];
                        sout_nxt  = 1'b0;
                        state_nxt = START;
                    end else begin
                        sout_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                START: begin
                    sout_nxt  = shreg[DATA_W-1];
                    shreg_nxt = shreg << 1;
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                end
                DATA: begin
                    if (cnt != LAST_BIT) begin
                        sout_nxt  = shreg[DATA_W-1];
                        shreg_nxt = shreg << 1;
                        cnt_nxt   = cnt + 1'b1;
                    end else begin
                        sout_nxt  = par;
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    sout_nxt  = 1'b1;
                    state_nxt = STOP;
                end
                default: begin
                    sout_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
